// File: rtl/bf_result_drain_if.sv
// Valid/ready word stream carrying drained Bellman-Ford results toward the host side.
// out_last tags the final word of each drain.
interface bf_result_drain_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/bf_result_drain.sv
// Drains the engine result memory after finish: one header word, then cnt distance words,
// streamed through a 2-entry buffer so memory reads never stall mid-word.
module bf_result_drain #(
    parameter int              ADDR_W    = 14,
    parameter int              DATA_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              finish,
    input  logic              n_exist,
    input  logic [ADDR_W-1:0] num_results,
    output logic [ADDR_W-1:0] output_address,
    input  logic [DATA_W-1:0] final_output,
    bf_result_drain_if.master stream,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_RD,
        S_DONE_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic              fin_prev_q, fin_prev_d;
    logic              armed_q, armed_d;
    logic              neg_q, neg_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] buf_data_q [0:1];
    logic [DATA_W-1:0] buf_data_d [0:1];
    logic              buf_last_q [0:1];
    logic              buf_last_d [0:1];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    logic              full;
    logic              valid;
    logic              pop;
    logic              start;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              push_last;
    logic [DATA_W-1:0] hdr_word;

    assign full  = (count_q == 2'd2);
    assign valid = (count_q != 2'd0);
    assign pop   = valid && stream.out_ready;
    // armed_q blocks a restart after reset until finish has been seen low once
    assign start = finish && !fin_prev_q && armed_q && (state_q == S_IDLE);

    always_comb begin
        hdr_word                 = '0;
        hdr_word[DATA_W-1]       = neg_q;
        hdr_word[ADDR_W-1:0]     = cnt_q;
    end

    always_comb begin
        state_d    = state_q;
        fin_prev_d = finish;
        armed_d    = armed_q | ~finish;
        neg_d      = neg_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        done_d     = pop && buf_last_q[rd_ptr_q] && busy_q;
        push       = 1'b0;
        push_data  = '0;
        push_last  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    neg_d   = n_exist;
                    cnt_d   = num_results;
                    busy_d  = 1'b1;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (!full) begin
                    push      = 1'b1;
                    push_data = hdr_word;
                    push_last = neg_q || (cnt_q == '0);
                    addr_d    = BASE_ADDR;
                    rem_d     = cnt_q;
                    state_d   = push_last ? S_DONE_WAIT : S_RD;
                end
            end
            S_RD: begin
                if (!full) begin
                    push      = 1'b1;
                    push_data = final_output;
                    push_last = (rem_q == ADDR_W'(1));
                    addr_d    = addr_q + ADDR_W'(1);
                    rem_d     = rem_q - ADDR_W'(1);
                    if (push_last) begin
                        state_d = S_DONE_WAIT;
                    end
                end
            end
            S_DONE_WAIT: begin
                // done_q marks that the tagged last word left the buffer one edge ago
                if (done_q && (count_q == 2'd0)) begin
                    busy_d  = 1'b0;
                    addr_d  = BASE_ADDR;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        buf_data_d = buf_data_q;
        buf_last_d = buf_last_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            buf_data_d[wr_ptr_q] = push_data;
            buf_last_d[wr_ptr_q] = push_last;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fin_prev_q <= 1'b0;
            armed_q    <= 1'b0;
            neg_q      <= 1'b0;
            cnt_q      <= '0;
            rem_q      <= '0;
            addr_q     <= BASE_ADDR;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            buf_data_q <= '{default: '0};
            buf_last_q <= '{default: 1'b0};
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            fin_prev_q <= fin_prev_d;
            armed_q    <= armed_d;
            neg_q      <= neg_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            buf_data_q <= buf_data_d;
            buf_last_q <= buf_last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign output_address   = addr_q;
    assign stream.out_data  = buf_data_q[rd_ptr_q];
    assign stream.out_valid = valid;
    assign stream.out_last  = valid && buf_last_q[rd_ptr_q];
    assign busy             = busy_q;
    assign done             = done_q;
endmodule

// File: tb/tb_bf_result_drain.sv
// Self-checking bench for bf_result_drain: two instances (base 0 and base 16380) share stimulus;
// expected streams come from a queue model built directly from the drain rules.
module tb_bf_result_drain;
    localparam int AW = 14;
    localparam int DW = 16;
    localparam logic [AW-1:0] BASE_B = 14'd16380;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          finish = 1'b0;
    logic          n_exist = 1'b0;
    logic          out_ready = 1'b0;
    logic          mon_b = 1'b0;
    logic [AW-1:0] num_results = '0;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] fo_a, fo_b;
    logic          busy_a, done_a, busy_b, done_b;
    logic [DW-1:0] mem [0:16383];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int pat [6] = '{1, 0, 0, 1, 0, 1};

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } word_t;
    word_t exp_q[$];
    word_t got_q[$];
    int    got_off[$];

    int r_done, r_busy, r_stall, r_dpulse, r_addr_err, r_stray;

    bf_result_drain_if #(.DATA_W(DW)) s_a ();
    bf_result_drain_if #(.DATA_W(DW)) s_b ();
    assign s_a.out_ready = out_ready;
    assign s_b.out_ready = out_ready;
    assign fo_a = mem[addr_a];
    assign fo_b = mem[addr_b];

    bf_result_drain #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(14'd0)) dut_a (
        .clock(clock), .reset(reset), .finish(finish), .n_exist(n_exist),
        .num_results(num_results), .output_address(addr_a), .final_output(fo_a),
        .stream(s_a), .busy(busy_a), .done(done_a)
    );
    bf_result_drain #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE_B)) dut_b (
        .clock(clock), .reset(reset), .finish(finish), .n_exist(n_exist),
        .num_results(num_results), .output_address(addr_b), .final_output(fo_b),
        .stream(s_b), .busy(busy_b), .done(done_b)
    );

    wire          m_valid = mon_b ? s_b.out_valid : s_a.out_valid;
    wire          m_last  = mon_b ? s_b.out_last  : s_a.out_last;
    wire [DW-1:0] m_data  = mon_b ? s_b.out_data  : s_a.out_data;
    wire          m_busy  = mon_b ? busy_b : busy_a;
    wire          m_done  = mon_b ? done_b : done_a;
    wire [AW-1:0] m_addr  = mon_b ? addr_b : addr_a;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference stream: header, then cnt words from base upward modulo 2^14, last tag on the final word.
    function automatic void build_exp(input bit neg, input int cnt, input int base);
        logic [DW-1:0] hdr;
        hdr = {neg, 1'b0, 14'(cnt)};
        exp_q.delete();
        if (neg || cnt == 0) begin
            exp_q.push_back('{d: hdr, l: 1'b1});
        end else begin
            exp_q.push_back('{d: hdr, l: 1'b0});
            for (int i = 0; i < cnt; i++)
                exp_q.push_back('{d: mem[(base + i) % 16384], l: (i == cnt - 1)});
        end
    endfunction

    // Starts a drain and records what the monitored instance streams; rmode 0=ready high, 1=pattern, 2=random.
    task automatic run_drain(input bit neg, input int cnt, input int rmode, input bit glitch);
        int t0, off;
        bit prev_stall;
        logic [DW-1:0] prev_data;
        got_q.delete();
        got_off.delete();
        r_done = -1; r_busy = -1; r_stall = 0; r_dpulse = 0; r_addr_err = 0; r_stray = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        @(negedge clock);
        n_exist = neg;
        num_results = 14'(cnt);
        finish = 1'b1;
        out_ready = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            off = cyc - t0;
            if (glitch && off == 3) finish = 1'b0;
            if (glitch && off == 4) finish = 1'b1;
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = pat[off % 6][0];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (prev_stall && (!m_valid || m_data !== prev_data)) r_stall++;
            prev_stall = m_valid && !out_ready;
            prev_data = m_data;
            if (neg && m_addr !== (mon_b ? BASE_B : 14'd0)) r_addr_err++;
            if (m_done) begin
                r_dpulse++;
                if (r_done < 0) r_done = off;
            end
            if (r_done >= 0 && !m_busy) begin
                r_busy = off;
                break;
            end
            if (m_valid && out_ready) begin
                got_q.push_back('{d: m_data, l: m_last});
                got_off.push_back(off);
                $display("word %0d data=%h last=%b off=%0d", got_q.size() - 1, m_data, m_last, off);
            end
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (m_valid || m_done || m_last || m_busy) r_stray++;
        end
        finish = 1'b0;
        $display("drain neg=%0d cnt=%0d words=%0d done_off=%0d", neg, cnt, got_q.size(), r_done);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++; if (s_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", s_a.out_valid); end
        checks++; if (s_a.out_data !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", s_a.out_data); end
        checks++; if ({s_a.out_last, busy_a, done_a} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {s_a.out_last, busy_a, done_a}); end
        checks++; if (addr_a !== 14'd0 || addr_b !== BASE_B) begin errors++; $display("FAIL reset_addr got %0d/%0d want 0/%0d", addr_a, addr_b, BASE_B); end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (s_a.out_valid !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL idle_quiet got valid=%b busy=%b want 0 0", s_a.out_valid, busy_a); end
    endtask

    task automatic test_normal();
        mon_b = 1'b0;
        mem[0] = 16'h0005; mem[1] = 16'h0000; mem[2] = 16'h0007; mem[3] = 16'h0003;
        build_exp(1'b0, 4, 0);
        run_drain(1'b0, 4, 0, 1'b0);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL normal_len got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL normal_word%0d got %h/%b want %h/%b", i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l); end
            checks++; if (got_off[i] != i + 2) begin errors++; $display("FAIL normal_cycle%0d got %0d want %0d", i, got_off[i], i + 2); end
        end
        checks++; if (r_done != 7) begin errors++; $display("FAIL normal_done got %0d want 7", r_done); end
        checks++; if (r_busy != 8) begin errors++; $display("FAIL normal_busy_low got %0d want 8", r_busy); end
        checks++; if (r_dpulse != 1 || r_stray != 0) begin errors++; $display("FAIL normal_pulse got %0d/%0d want 1/0", r_dpulse, r_stray); end
    endtask

    task automatic test_negative();
        mon_b = 1'b0;
        run_drain(1'b1, 8, 0, 1'b0);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL neg_len got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            checks++; if (got_q[0].d !== 16'h8008 || got_q[0].l !== 1'b1) begin errors++; $display("FAIL neg_word got %h/%b want 8008/1", got_q[0].d, got_q[0].l); end
        end
        checks++; if (r_addr_err != 0) begin errors++; $display("FAIL neg_addr got %0d moves want 0", r_addr_err); end
        checks++; if (r_dpulse != 1) begin errors++; $display("FAIL neg_done got %0d pulses want 1", r_dpulse); end
    endtask

    task automatic test_backpressure();
        mon_b = 1'b0;
        build_exp(1'b0, 4, 0);
        run_drain(1'b0, 4, 1, 1'b0);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_len got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word%0d got %h/%b want %h/%b", i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l); end
        end
        checks++; if (r_stall != 0) begin errors++; $display("FAIL bp_stable got %0d violations want 0", r_stall); end
        checks++; if (r_dpulse != 1) begin errors++; $display("FAIL bp_done got %0d pulses want 1", r_dpulse); end
    endtask

    task automatic test_zero();
        mon_b = 1'b0;
        run_drain(1'b0, 0, 0, 1'b0);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL zero_len got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            checks++; if (got_q[0].d !== 16'h0000 || got_q[0].l !== 1'b1) begin errors++; $display("FAIL zero_word got %h/%b want 0000/1", got_q[0].d, got_q[0].l); end
        end
    endtask

    task automatic test_reset_mid();
        int acc = 0;
        int bad = 0;
        mon_b = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        @(negedge clock);
        n_exist = 1'b0; num_results = 14'd16; finish = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 40 && acc < 3; k++) begin
            @(negedge clock);
            if (s_a.out_valid) acc++;
        end
        checks++; if (acc != 3) begin errors++; $display("FAIL rstmid_start got %0d words want 3", acc); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if ({s_a.out_valid, s_a.out_last, busy_a, done_a} !== 4'b0000 || s_a.out_data !== 16'h0) begin
            errors++; $display("FAIL rstmid_outputs got v%b l%b b%b d%b data=%h want all 0", s_a.out_valid, s_a.out_last, busy_a, done_a, s_a.out_data);
        end
        checks++; if (addr_a !== 14'd0) begin errors++; $display("FAIL rstmid_addr got %0d want 0", addr_a); end
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (s_a.out_valid || busy_a || done_a) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_quiet got %0d active cycles want 0", bad); end
        finish = 1'b0;
        build_exp(1'b0, 16, 0);
        run_drain(1'b0, 16, 0, 1'b0);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_len got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_word%0d got %h/%b want %h/%b", i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l); end
        end
    endtask

    task automatic test_wrap();
        mon_b = 1'b1;
        for (int i = 0; i < 8; i++) mem[(16380 + i) % 16384] = 16'($urandom);
        build_exp(1'b0, 6, 16380);
        run_drain(1'b0, 6, 2, 1'b0);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_len got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_word%0d got %h/%b want %h/%b", i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l); end
        end
        checks++; if (r_stall != 0) begin errors++; $display("FAIL wrap_stable got %0d violations want 0", r_stall); end
        mon_b = 1'b0;
    endtask

    task automatic test_back_to_back();
        mon_b = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
        build_exp(1'b0, 8, 0);
        run_drain(1'b0, 8, 0, 1'b1);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_len got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word%0d got %h/%b want %h/%b", i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l); end
        end
        checks++; if (r_stray != 0 || r_dpulse != 1) begin errors++; $display("FAIL b2b_ignore got stray=%0d pulses=%0d want 0/1", r_stray, r_dpulse); end
    endtask

    task automatic test_random();
        bit neg;
        int cnt, base;
        for (int it = 0; it < 8; it++) begin
            mon_b = 1'($urandom_range(0, 1));
            base = mon_b ? 16380 : 0;
            neg = ($urandom_range(0, 3) == 0);
            cnt = $urandom_range(0, 20);
            for (int i = 0; i < 24; i++) mem[(base + i) % 16384] = 16'($urandom);
            build_exp(neg, cnt, base);
            run_drain(neg, cnt, 2, 1'b0);
            checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_len got %0d want %0d", it, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_word%0d got %h/%b want %h/%b", it, i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l); end
            end
            checks++; if (r_stall != 0 || r_dpulse != 1 || r_stray != 0) begin
                errors++; $display("FAIL rand%0d_proto got stall=%0d pulses=%0d stray=%0d want 0/1/0", it, r_stall, r_dpulse, r_stray);
            end
        end
        mon_b = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
        test_reset();
        test_normal();
        test_negative();
        test_backpressure();
        test_zero();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bf_result_drain.md
Name: bf_result_drain

Overview:
- Downstream consumer of the Bellman-Ford engine top level.
- After the engine raises finish, this block walks the 16-bit result memory through the engine's output_address/final_output read port.
- It streams a header word and then the distance words onto a valid/ready stream toward the host/UART side.
- An internal 2-entry buffer absorbs backpressure, so memory reads never stall mid-word.

Parameters:
- ADDR_W, 14, width of the result-memory address (matches output_address).
- DATA_W, 16, width of a result word (matches final_output).
- BASE_ADDR, 0, first result-memory address drained.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- finish  input  1  engine done level; a rising edge starts a drain.
- n_exist  input  1  engine negative-cycle flag; sampled on the finish rising edge.
- num_results  input  ADDR_W  number of distance words to drain; sampled on the finish rising edge.
- output_address  output  ADDR_W  read address to the result memory.
- final_output  input  DATA_W  result-memory read data for the presented address; combinational read.
- out_data  output  DATA_W  stream data.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready.
- out_last  output  1  marks the final word of a drain.
- busy  output  1  high from drain start until the last word is accepted.
- done  output  1  one-cycle pulse when the last word is accepted.

Behaviour:
- Reset values: output_address=BASE_ADDR, out_data=0, out_valid=0, out_last=0, busy=0, done=0; buffer emptied; state IDLE; finish edge detector register cleared to 0.
- Reset mid-drain aborts immediately. No further words appear, even if finish stays high. A new drain needs finish to fall and rise again.
- Start condition: finish==1 while the previous-cycle finish register is 0, in state IDLE.
  - On start, latch neg=n_exist and cnt=num_results.
  - busy goes high on the next cycle.
  - A rising edge outside IDLE is ignored.
- FSM states:
  - IDLE: wait for the start condition, then go to HDR.
  - HDR: push header word {neg, 1'b0, cnt[13:0]} into the buffer when it is not full.
    - Go to DONE_WAIT if neg==1 or cnt==0; otherwise go to RD.
    - In both exit cases output_address is set to BASE_ADDR.
  - RD: each cycle the buffer has a free slot, capture final_output (for the current output_address) into the buffer.
    - Increment output_address in the same edge.
    - After capturing word cnt-1, go to DONE_WAIT.
    - The address is held whenever the buffer is full.
  - DONE_WAIT: wait until the buffer is empty and the last word has been accepted. Pulse done, clear busy, go to IDLE.
- Buffer: 2-entry FIFO; out_data/out_valid are driven from the head entry.
  - A word transfers on a cycle with out_valid && out_ready.
  - Push and pop on the same cycle with 1 entry present leaves occupancy at 1.
  - Push is suppressed while full. A pop is always permitted.
- out_last is asserted with the final word of the drain, carried as a per-entry tag:
  - the header when neg==1 or cnt==0;
  - otherwise the distance word read from address BASE_ADDR+cnt-1.
- out_valid must not drop once asserted until the handshake completes; out_data is stable while valid && !ready.
- Throughput: with out_ready held high, one word per cycle.
  - Header appears on out_valid 2 cycles after the finish rising edge.
  - Distance words follow in consecutive cycles.
- Address arithmetic is modulo 2^ADDR_W: BASE_ADDR+cnt wraps silently, and the drain reads exactly cnt words.
- When neg==1, distance words are never read; the stream contains the header only.
- done and out_last are never asserted outside a drain.

Test Plan:
- Normal drain:
  - Stimulus: num_results=4, n_exist=0, memory[0..3]=0x0005,0x0000,0x0007,0x0003, finish rises at cycle T, out_ready=1.
  - Response: words 0x0004,0x0005,0x0000,0x0007,0x0003 on cycles T+2..T+6, out_last only on 0x0003, done pulse on T+7, busy low at T+8.
- Negative cycle:
  - Stimulus: n_exist=1, num_results=8.
  - Response: a single word 0x8008 with out_last=1; output_address never leaves BASE_ADDR; done after its acceptance.
- Backpressure:
  - Stimulus: same setup as normal drain, with out_ready toggled 1,0,0,1,0,1,...
  - Response: identical 5-word sequence, no drops or duplicates, out_data stable during stalls, output_address frozen while the buffer is full.
- Zero-length drain:
  - Stimulus: num_results=0, n_exist=0.
  - Response: single header 0x0000 with out_last=1.
- Reset mid-drain:
  - Stimulus: num_results=16, assert reset after 3 words accepted, finish held high.
  - Response: all outputs return to reset values next cycle; no further words appear until finish falls and rises again, which restarts the drain from the header.
- Wrap:
  - Stimulus: BASE_ADDR=16380, num_results=6.
  - Response: addresses 16380..16383, 0, 1 are read in order.
